// File: rtl/ntt_stage_ctrl.sv
// Stage/butterfly sequencer for an in-place forward Cooley-Tukey NTT over an N-point RAM.
// Optional NTT_CTRL_PERF_EN adds a 32-bit busy-cycle counter output (cycle_cnt).
module ntt_stage_ctrl #(
  parameter int unsigned N      = 256,
  parameter int unsigned LOG_N  = 8,
  parameter int unsigned BF_LAT = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [LOG_N-1:0]        rd_addr_a,
  output logic [LOG_N-1:0]        rd_addr_b,
  output logic [LOG_N-1:0]        tw_addr,
  output logic                    bf_en,
  output logic                    wr_en,
  output logic [LOG_N-1:0]        wr_addr_a,
  output logic [LOG_N-1:0]        wr_addr_b,
  output logic [$clog2(LOG_N):0]  stage
`ifdef NTT_CTRL_PERF_EN
  ,
  output logic [31:0]             cycle_cnt
`endif
);

  localparam int unsigned AW = LOG_N;
  localparam int unsigned KW = LOG_N - 1;
  localparam int unsigned SW = $clog2(LOG_N) + 1;
  localparam int unsigned PD = BF_LAT + 1;
  localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG_N - 1);
  localparam logic [PD-1:0] PIPE_LAST_ONLY = PD'(1) << (PD - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [KW-1:0]   k_q, k_d;
  logic            rd_en_d;
  logic [AW-1:0]   rd_a_d, rd_b_d, tw_d;
  logic [AW-1:0]   kx, half_c, g_c, j_c, base_c;
  logic            last_wr_c;

  logic [PD-1:0]   pipe_v;
  logic [AW-1:0]   pipe_a [PD];
  logic [AW-1:0]   pipe_b [PD];

  // Last write of the stage: only the exit slot of the tag pipe is still valid.
  assign last_wr_c = (pipe_v == PIPE_LAST_ONLY);

  assign wr_en     = pipe_v[PD-1];
  assign wr_addr_a = pipe_a[PD-1];
  assign wr_addr_b = pipe_b[PD-1];

  // Next-state and stage/butterfly counters.
  always_comb begin
    state_d = state;
    s_d     = s_q;
    k_d     = k_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          s_d     = '0;
          k_d     = '0;
        end
      end
      ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DRAIN: begin
        if (last_wr_c) begin
          if (s_q == S_LAST) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            s_d     = s_q + SW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Butterfly indexing from next (s, k): group/offset by shifts and masks only.
  always_comb begin
    kx      = AW'(k_d);
    half_c  = AW'(N >> (s_d + SW'(1)));
    g_c     = kx >> (SW'(KW) - s_d);
    j_c     = kx & (half_c - AW'(1));
    base_c  = (g_c << (SW'(AW) - s_d)) | j_c;
    rd_en_d = (state_d == ISSUE);
    rd_a_d  = '0;
    rd_b_d  = '0;
    tw_d    = '0;
    if (rd_en_d) begin
      rd_a_d = base_c;
      rd_b_d = base_c | half_c;
      tw_d   = (AW'(1) << s_d) | g_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      s_q       <= '0;
      k_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      bf_en     <= 1'b0;
      stage     <= '0;
      pipe_v    <= '0;
      for (int unsigned i = 0; i < PD; i++) begin
        pipe_a[i] <= '0;
        pipe_b[i] <= '0;
      end
    end else begin
      state     <= state_d;
      s_q       <= s_d;
      k_q       <= k_d;
      busy      <= (state_d == ISSUE) || (state_d == DRAIN);
      done      <= (state_d == DONE);
      rd_en     <= rd_en_d;
      rd_addr_a <= rd_a_d;
      rd_addr_b <= rd_b_d;
      tw_addr   <= tw_d;
      bf_en     <= rd_en || (state == DRAIN);
      stage     <= s_d;
      // Tag pipe shifts every cycle, independent of the butterfly's own valid.
      pipe_v[0] <= rd_en;
      pipe_a[0] <= rd_addr_a;
      pipe_b[0] <= rd_addr_b;
      for (int unsigned i = 1; i < PD; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
        pipe_b[i] <= pipe_b[i-1];
      end
    end
  end

`ifdef NTT_CTRL_PERF_EN
  // Busy-cycle counter; restarts on an accepted start and holds after done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      cycle_cnt <= '0;
    end else if (busy) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ntt_stage_ctrl.md
Name: ntt_stage_ctrl

Overview:
- Sequencer for one butterfly datapath (ntt2_pipeline-class: `Datawidth+1`-bit operands, fixed latency, advances only while its enable is high).
- Runs a full in-place forward Cooley-Tukey NTT over an N-point coefficient RAM:
  - LOG_N stages, N/2 butterflies per stage.
  - Generates RAM read/write addresses, the twiddle-ROM address and the butterfly enable.
- Drains the butterfly between stages so that no read-after-write hazard exists.

Parameters:
- N, 256, transform length; power of two, at least 4.
- LOG_N, 8, log2(N).
- BF_LAT, 5, cycles from butterfly en-sample to its outputs being valid (matches the butterfly top).

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request to start a transform; sampled only in IDLE.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, one-cycle pulse when the last stage is written back.
- rd_en, output, 1, RAM read strobe; RAM data returns 1 cycle later.
- rd_addr_a, output, LOG_N, address of the x operand.
- rd_addr_b, output, LOG_N, address of the y operand.
- tw_addr, output, LOG_N, twiddle ROM address; ROM output aligned with the RAM data.
- bf_en, output, 1, butterfly enable.
- wr_en, output, 1, RAM write strobe for the xout/yout pair.
- wr_addr_a, output, LOG_N, xout destination.
- wr_addr_b, output, LOG_N, yout destination.
- stage, output, $clog2(LOG_N)+1, current stage index (status).

Behaviour:
- Reset: FSM=IDLE; all outputs 0; address counters and tag pipe cleared. Reset mid-transform aborts immediately; RAM contents undefined.
- States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE -> ISSUE on start. Clear s=0, k=0.
  - ISSUE: rd_en=1 for N/2 consecutive cycles, k=0..N/2-1. After k=N/2-1 -> DRAIN.
  - DRAIN: wait until the last tagged write of the stage has been issued (wr_en high that cycle). Then s<LOG_N-1 -> ISSUE with s+1, k=0; else -> DONE.
  - DONE: done=1 for one cycle; -> IDLE.
  - start while busy is ignored.
- Indexing for stage s and butterfly k:
  - half = N>>(s+1); g = k/half; j = k%half.
  - rd_addr_a = 2*half*g + j; rd_addr_b = rd_addr_a + half.
  - tw_addr = (1<<s) + g (bit-reversed zeta table; entry 0 unused).
  - All divisions are shifts and masks; no multipliers.
- Timing, with cycle 1 = first ISSUE cycle of a stage:
  - rd_en high cycles 1..N/2.
  - bf_en = rd_en registered, OR DRAIN-state registered. The butterfly therefore stays enabled from cycle 2 through the end of DRAIN, so its internal operand delay line keeps advancing.
  - wr_en high cycles 2+BF_LAT .. N/2+1+BF_LAT.
  - Stage period P = N/2+BF_LAT+1.
  - done in cycle LOG_N*P+1 after start sampled; busy deasserts the same cycle done is high.
- Write-back tracking:
  - A 1+BF_LAT deep shift pipe carries {valid, addr_a, addr_b} from each read.
  - At the pipe exit it drives wr_en/wr_addr_a/wr_addr_b.
  - The pipe always shifts; it is independent of the butterfly's valid output.
- Boundaries:
  - Last butterfly of a stage: write completes before the next stage's first read (strict drain).
  - k wraps to 0 at the stage boundary.
  - s never exceeds LOG_N-1.

Optional Feature:
- Macro: NTT_CTRL_PERF_EN.
- Defined:
  - Adds output cycle_cnt, 32 bits.
  - Cleared on reset and on accepted start.
  - Increments every busy cycle.
  - Holds its value after done until the next start.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- N=8, BF_LAT=5, start pulse -> stage0 reads (0,4),(1,5),(2,6),(3,7) with tw=1; first wr_en 6 cycles after the first rd_en, same address pair.
- Same run -> stage1 pairs (0,2),(1,3) tw=2 and (4,6),(5,7) tw=3; stage2 pairs (0,1),(2,3),(4,5),(6,7) with tw=4,5,6,7; done exactly 31 cycles after start sampled.
- Full N=256 transform with RAM model and golden software NTT mod `p -> RAM matches the reference vector; no rd_addr equals any pending write address during a stage.
- start pulsed while busy, in stage 1 -> ignored; done still at cycle 31 (N=8); exactly one done pulse.
- reset asserted during stage 1 DRAIN -> all outputs 0 asynchronously; after release, a new start runs a clean full transform with the same timing.
- NTT_CTRL_PERF_EN defined, N=8 -> cycle_cnt=30 at the done pulse and holds 30 afterwards.
